// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W stage has priority, MD results queue and drain on idle W cycles.
// Optional trace output is enabled by defining GRF_WB_TRACE_EN.
module grf_wb_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_a3,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    output logic        w_hold,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_a3,
    input  logic [31:0] md_wd,
    input  logic [31:0] md_pc,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        q_busy,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [4:0]    r_q_a3 [DEPTH];
    logic [31:0]   r_q_wd [DEPTH];
    logic [31:0]   r_q_pc [DEPTH];
    logic [CW-1:0] r_count;
    logic [WW-1:0] r_wait;
    logic          r_grf_we;
    logic [4:0]    r_grf_a3;
    logic [31:0]   r_grf_wd;
    logic [31:0]   r_grf_pc;

    logic          w_w_req;
    logic          w_nonempty;
    logic          w_force;
    logic          w_pop;
    logic          w_grant_w;
    logic          w_enq;
    logic          w_q1_ok;
    logic          w_q2_ok;
    logic [DEPTH-1:0] w_kill;
    logic [4:0]    w_n_a3 [DEPTH];
    logic [31:0]   w_n_wd [DEPTH];
    logic [31:0]   w_n_pc [DEPTH];
    logic [CW-1:0] w_n_count;

    assign w_w_req    = w_we && (w_a3 != 5'd0);
    assign w_nonempty = (r_count != '0);
    assign w_force    = w_nonempty && (r_wait == WAIT_MAX);
    assign w_pop      = w_nonempty && (w_force || !w_w_req);
    assign w_grant_w  = w_w_req && !w_force;
    assign w_hold     = w_force && w_w_req;
    assign md_ready   = (r_count < CW'(DEPTH));
    assign w_enq      = md_valid && md_ready && (md_a3 != 5'd0);
    assign w_q1_ok    = (q_a1 != 5'd0);
    assign w_q2_ok    = (q_a2 != 5'd0);

    assign grf_we = r_grf_we;
    assign grf_a3 = r_grf_a3;
    assign grf_wd = r_grf_wd;
    assign grf_pc = r_grf_pc;

    // A granted W write supersedes any older queued result for the same register.
    always_comb begin
        w_kill = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            w_kill[i] = w_grant_w && (i < 32'(r_count)) && (r_q_a3[i] == w_a3);
    end

    // Queue kept compacted at index 0 so pops and kills both preserve order.
    always_comb begin
        int unsigned k;
        k      = 0;
        w_n_a3 = r_q_a3;
        w_n_wd = r_q_wd;
        w_n_pc = r_q_pc;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((i < 32'(r_count)) && !(w_pop && (i == 0)) && !w_kill[i]) begin
                w_n_a3[IW'(k)] = r_q_a3[i];
                w_n_wd[IW'(k)] = r_q_wd[i];
                w_n_pc[IW'(k)] = r_q_pc[i];
                k = k + 1;
            end
        end
        if (w_enq) begin
            w_n_a3[IW'(k)] = md_a3;
            w_n_wd[IW'(k)] = md_wd;
            w_n_pc[IW'(k)] = md_pc;
            k = k + 1;
        end
        w_n_count = CW'(k);
    end

    always_comb begin
        q_busy = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((i < 32'(r_count)) &&
                ((w_q1_ok && (r_q_a3[i] == q_a1)) || (w_q2_ok && (r_q_a3[i] == q_a2))))
                q_busy = 1'b1;
        end
        if (w_enq && ((w_q1_ok && (md_a3 == q_a1)) || (w_q2_ok && (md_a3 == q_a2))))
            q_busy = 1'b1;
        if (r_grf_we && ((w_q1_ok && (r_grf_a3 == q_a1)) || (w_q2_ok && (r_grf_a3 == q_a2))))
            q_busy = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_wait   <= '0;
            r_grf_we <= 1'b0;
            r_grf_a3 <= '0;
            r_grf_wd <= '0;
            r_grf_pc <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q_a3[i] <= '0;
                r_q_wd[i] <= '0;
                r_q_pc[i] <= '0;
            end
        end else begin
            r_count <= w_n_count;
            r_q_a3  <= w_n_a3;
            r_q_wd  <= w_n_wd;
            r_q_pc  <= w_n_pc;
            if (!w_nonempty || w_pop || w_kill[0])
                r_wait <= '0;
            else if (r_wait != WAIT_MAX)
                r_wait <= r_wait + 1'b1;
            if (w_grant_w) begin
                r_grf_we <= 1'b1;
                r_grf_a3 <= w_a3;
                r_grf_wd <= w_wd;
                r_grf_pc <= w_pc;
            end else if (w_pop) begin
                r_grf_we <= 1'b1;
                r_grf_a3 <= r_q_a3[0];
                r_grf_wd <= r_q_wd[0];
                r_grf_pc <= r_q_pc[0];
            end else begin
                r_grf_we <= 1'b0;
            end
        end
    end

`ifdef GRF_WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && r_grf_we && (r_grf_a3 != 5'd0))
            $display("%d@%h: $%d <= %h", $time, r_grf_pc, r_grf_a3, r_grf_wd);
        for (int unsigned i = 0; i < DEPTH; i++)
            if (!reset && w_kill[i])
                $display("%d@%h: WAW kill $%d", $time, r_q_pc[i], r_q_a3[i]);
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule
